// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB writeback stage: result sources, load
// funct3 codes and the RUN/WAIT handshake states.
package wb_pkg;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;
   localparam logic [1:0] RES_IMM  = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      WB_RUN  = 1'b0,
      WB_WAIT = 1'b1
   } wb_state_e;

   // A flushed or empty slot never counts as a load, whatever its result source.
   function automatic logic is_load_op(input logic valid,
                                       input logic flush,
                                       input logic [1:0] src);
      return valid & ~flush & (src == RES_LOAD);
   endfunction

endpackage

// File: rtl/load_extract.sv
// Load data extraction: shift the read word down by the byte offset, then
// sign- or zero-extend a byte, halfword or word to XLEN.
module load_extract
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] data,
   output logic [XLEN-1:0] result
);

   logic [XLEN-1:0] sh;

   // Misaligned accesses fall through naturally: the shift zero-fills the
   // bytes beyond the end of the word before extension.
   always_comb begin
      sh     = data >> {offset, 3'b000};
      result = '0;
      case (funct3)
         F3_LB:   result = XLEN'($signed(sh[7:0]));
         F3_LBU:  result = XLEN'(sh[7:0]);
         F3_LH:   result = XLEN'($signed(sh[15:0]));
         F3_LHU:  result = XLEN'(sh[15:0]);
         default: result = XLEN'($signed(sh[31:0]));
      endcase
   end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register with 4-way writeback select and a RUN/WAIT load
// handshake with timeout. Optional retire counter enabled by WB_RETIRE_COUNT_EN.
module wb_stage_pipe
   import wb_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int REG_AW       = 5,
   parameter int LOAD_TIMEOUT = 16,
   parameter int RETIRE_W     = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_m,
   input  logic              flush_m,
   input  logic              reg_write_m,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [1:0]        result_src_m,
   input  logic [2:0]        funct3_m,
   input  logic [XLEN-1:0]   alu_result_m,
   input  logic [XLEN-1:0]   pc_plus4_m,
   input  logic [XLEN-1:0]   imm_ext_m,
   input  logic [XLEN-1:0]   read_data_m,
   input  logic              read_valid_m,
   output logic              valid_w,
   output logic              reg_write_w,
   output logic [REG_AW-1:0] rd_w,
   output logic [XLEN-1:0]   result_w,
   output logic              load_stall_o,
   output logic              load_err_o
`ifdef WB_RETIRE_COUNT_EN
   ,
   output logic [RETIRE_W-1:0] retire_count_o
`endif
);

   localparam int CW = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);

   if (XLEN < 32 || LOAD_TIMEOUT < 1 || RETIRE_W < 1) begin : g_param_check
      $error("wb_stage_pipe: XLEN must be >= 32, LOAD_TIMEOUT and RETIRE_W >= 1");
   end

   wb_state_e         state;
   logic [CW-1:0]     wait_cnt;
   logic              reg_write_q;

   logic [REG_AW-1:0] pend_rd;
   logic              pend_wr;
   logic [2:0]        pend_f3;
   logic [1:0]        pend_off;

   logic [2:0]        ext_f3;
   logic [1:0]        ext_off;
   logic [XLEN-1:0]   ext_data;
   logic [XLEN-1:0]   sel_result;
   logic              load_m;

   // While waiting, the extractor must use the captured load shape since the
   // M-stage fields are only guaranteed stable, not necessarily meaningful.
   always_comb begin
      ext_f3  = funct3_m;
      ext_off = alu_result_m[1:0];
      if (state == WB_WAIT) begin
         ext_f3  = pend_f3;
         ext_off = pend_off;
      end
   end

   load_extract #(
      .XLEN(XLEN)
   ) u_load_extract (
      .funct3(ext_f3),
      .offset(ext_off),
      .data  (read_data_m),
      .result(ext_data)
   );

   always_comb begin
      sel_result = alu_result_m;
      case (result_src_m)
         RES_ALU:  sel_result = alu_result_m;
         RES_LOAD: sel_result = ext_data;
         RES_PC4:  sel_result = pc_plus4_m;
         RES_IMM:  sel_result = imm_ext_m;
         default:  sel_result = alu_result_m;
      endcase
   end

   assign load_m = is_load_op(valid_m, flush_m, result_src_m);

   // Single state machine owning the W-stage registers and the pending load.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= WB_RUN;
         wait_cnt    <= '0;
         valid_w     <= 1'b0;
         reg_write_q <= 1'b0;
         rd_w        <= '0;
         result_w    <= '0;
         load_err_o  <= 1'b0;
         pend_rd     <= '0;
         pend_wr     <= 1'b0;
         pend_f3     <= '0;
         pend_off    <= '0;
      end else begin
         case (state)
            WB_RUN: begin
               if (!valid_m || flush_m) begin
                  valid_w <= 1'b0;
               end else if (load_m && !read_valid_m) begin
                  pend_rd  <= rd_m;
                  pend_wr  <= reg_write_m;
                  pend_f3  <= funct3_m;
                  pend_off <= alu_result_m[1:0];
                  valid_w  <= 1'b0;
                  wait_cnt <= CW'(1);
                  state    <= WB_WAIT;
               end else begin
                  valid_w     <= 1'b1;
                  reg_write_q <= reg_write_m;
                  rd_w        <= rd_m;
                  result_w    <= sel_result;
               end
            end
            WB_WAIT: begin
               // Data arriving on the timeout cycle still retires normally.
               if (read_valid_m) begin
                  valid_w     <= 1'b1;
                  reg_write_q <= pend_wr;
                  rd_w        <= pend_rd;
                  result_w    <= ext_data;
                  state       <= WB_RUN;
               end else if (wait_cnt == CW'(LOAD_TIMEOUT)) begin
                  valid_w     <= 1'b1;
                  reg_write_q <= 1'b0;
                  rd_w        <= pend_rd;
                  result_w    <= '0;
                  load_err_o  <= 1'b1;
                  state       <= WB_RUN;
               end else begin
                  valid_w  <= 1'b0;
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: state <= WB_RUN;
         endcase
      end
   end

   assign load_stall_o = (state == WB_WAIT);
   assign reg_write_w  = valid_w & reg_write_q & (rd_w != '0);

`ifdef WB_RETIRE_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_count_o <= '0;
      end else if (valid_w) begin
         retire_count_o <= retire_count_o + RETIRE_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe: stimulus pushes expected retirements,
// a negedge monitor pops and compares. Honours WB_RETIRE_COUNT_EN if defined.
module tb_wb_stage_pipe;
   import wb_pkg::*;

   localparam int TMO = 4;
   localparam int RW  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_m, flush_m, reg_write_m, read_valid_m;
   logic [4:0]  rd_m;
   logic [1:0]  result_src_m;
   logic [2:0]  funct3_m;
   logic [31:0] alu_result_m, pc_plus4_m, imm_ext_m, read_data_m;
   logic        valid_w, reg_write_w, load_stall_o, load_err_o;
   logic [4:0]  rd_w;
   logic [31:0] result_w;
`ifdef WB_RETIRE_COUNT_EN
   logic [RW-1:0] retire_count_o;
`endif

   wb_stage_pipe #(
      .XLEN(32), .REG_AW(5), .LOAD_TIMEOUT(TMO), .RETIRE_W(RW)
   ) dut (
      .clk(clk), .rst(rst),
      .valid_m(valid_m), .flush_m(flush_m), .reg_write_m(reg_write_m),
      .rd_m(rd_m), .result_src_m(result_src_m), .funct3_m(funct3_m),
      .alu_result_m(alu_result_m), .pc_plus4_m(pc_plus4_m),
      .imm_ext_m(imm_ext_m), .read_data_m(read_data_m),
      .read_valid_m(read_valid_m),
      .valid_w(valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
      .result_w(result_w), .load_stall_o(load_stall_o),
      .load_err_o(load_err_o)
`ifdef WB_RETIRE_COUNT_EN
      , .retire_count_o(retire_count_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          edge_no;
      logic [31:0] result;
      logic        wr;
      logic [4:0]  rd;
      bit          chk_rd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   edge_count = 0;
   int   retired_model = 0;
   bit   err_model = 1'b0;

   always @(posedge clk) edge_count <= edge_count + 1;

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (edge %0d)",
                  name, act, exp, edge_count);
      end
   endtask

   // Reference load: pick bytes from the word, missing bytes read as zero.
   function automatic logic [31:0] modelLoad(input logic [2:0] f3,
                                             input logic [1:0] off,
                                             input logic [31:0] data);
      logic [31:0] v;
      int n;
      bit sgn;
      int o;
      v = '0;
      o = int'(off);
      case (f3)
         3'b000:  begin n = 1; sgn = 1'b1; end
         3'b100:  begin n = 1; sgn = 1'b0; end
         3'b001:  begin n = 2; sgn = 1'b1; end
         3'b101:  begin n = 2; sgn = 1'b0; end
         default: begin n = 4; sgn = 1'b1; end
      endcase
      for (int i = 0; i < n; i++)
         if (o + i < 4) v[8*i +: 8] = data[8*(o+i) +: 8];
      if (sgn && v[8*n-1])
         for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   function automatic logic [31:0] modelResult(input logic [1:0] src,
         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
         input logic [31:0] imm, input logic [31:0] data);
      case (src)
         2'b00:   return alu;
         2'b01:   return modelLoad(f3, alu[1:0], data);
         2'b10:   return pc4;
         default: return imm;
      endcase
   endfunction

   // delay = number of edges with read data absent before it arrives.
   task automatic applyStimulus(input logic vld, input logic flush,
         input logic rw, input logic [4:0] rd, input logic [1:0] src,
         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
         input logic [31:0] imm, input logic [31:0] data, input int delay);
      bit   is_load;
      bit   tmo;
      int   hold;
      exp_t e;
      is_load = vld && !flush && (src == 2'b01);
      hold    = is_load ? ((delay < TMO) ? delay : TMO) : 0;
      tmo     = is_load && (delay > TMO);
      valid_m = vld; flush_m = flush; reg_write_m = rw; rd_m = rd;
      result_src_m = src; funct3_m = f3; alu_result_m = alu;
      pc_plus4_m = pc4; imm_ext_m = imm; read_data_m = data;
      read_valid_m = !is_load || (delay == 0);
      if (vld && !flush) begin
         e.edge_no = edge_count + 1 + hold;
         e.rd      = rd;
         if (tmo) begin
            e.result = '0; e.wr = 1'b0; e.chk_rd = 1'b0;
            err_model = 1'b1;
         end else begin
            e.result = modelResult(src, f3, alu, pc4, imm, data);
            e.wr     = rw && (rd != 5'd0);
            e.chk_rd = 1'b1;
         end
         exp_q.push_back(e);
         retired_model++;
      end
      @(posedge clk); #1;
      checkOutput("load_stall_o", load_stall_o, hold > 0);
      for (int k = 1; k <= hold; k++) begin
         read_valid_m = (k == delay);
         flush_m = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         checkOutput("load_stall_o", load_stall_o, k < hold);
      end
      checkOutput("load_err_o", load_err_o, err_model);
   endtask

   // Monitor: every retirement must land on its predicted edge, in order.
   always @(negedge clk) begin
      if (!rst) begin
         if (exp_q.size() > 0 && exp_q[0].edge_no == edge_count) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("valid_w", valid_w, 1'b1);
            if (valid_w === 1'b1) begin
               checkOutput("result_w", result_w, e.result);
               checkOutput("reg_write_w", reg_write_w, e.wr);
               if (e.chk_rd) checkOutput("rd_w", rd_w, e.rd);
            end
         end else if (valid_w === 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_retire actual valid_w=1 expected 0 (edge %0d)",
                     edge_count);
         end
      end
   end

   initial begin
      rst = 1'b1; valid_m = 0; flush_m = 0; reg_write_m = 0; rd_m = 0;
      result_src_m = 0; funct3_m = 0; alu_result_m = 0; pc_plus4_m = 0;
      imm_ext_m = 0; read_data_m = 0; read_valid_m = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid_w", valid_w, 1'b0);
      checkOutput("reset_reg_write_w", reg_write_w, 1'b0);
      checkOutput("reset_rd_w", rd_w, 5'd0);
      checkOutput("reset_result_w", result_w, 32'd0);
      checkOutput("reset_stall", load_stall_o, 1'b0);
      checkOutput("reset_err", load_err_o, 1'b0);
      rst = 1'b0;

      applyStimulus(1, 0, 1, 5'd5, RES_ALU, 3'd0, 32'h8, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 5'd7, RES_LOAD, F3_LB, 32'h2, 0, 0, 32'h80FF7F01, 0);
      applyStimulus(1, 0, 1, 5'd8, RES_LOAD, F3_LBU, 32'h3, 0, 0, 32'h80FF7F01, 0);
      applyStimulus(1, 0, 1, 5'd9, RES_LOAD, F3_LH, 32'h100, 0, 0, 32'h80FF7F01, 0);
      applyStimulus(1, 0, 1, 5'd10, RES_LOAD, F3_LHU, 32'h1002, 0, 0, 32'h80FF7F01, 0);
      applyStimulus(1, 0, 1, 5'd11, RES_LOAD, F3_LW, 32'h40, 0, 0, 32'hDEADBEEF, 3);
      applyStimulus(1, 0, 1, 5'd12, RES_LOAD, F3_LW, 32'h44, 0, 0, 32'h12345678, 100);
      applyStimulus(1, 1, 1, 5'd13, RES_ALU, 3'd0, 32'h55, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 5'd0, RES_ALU, 3'd0, 32'h66, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 5'd14, RES_PC4, 3'd0, 32'h0, 32'h104, 0, 0, 0);
      applyStimulus(1, 0, 1, 5'd15, RES_IMM, 3'd0, 32'h0, 0, 32'hFFFFF800, 0, 0);

      for (int n = 0; n < 300; n++) begin
         int d;
         d = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 7));
         applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                       $urandom, $urandom, $urandom, $urandom, d);
      end

      valid_m = 1'b0; flush_m = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
`ifdef WB_RETIRE_COUNT_EN
      checkOutput("retire_count_o", retire_count_o, RW'(retired_model));
`endif

      // Reset while a load is parked in WAIT.
      valid_m = 1; flush_m = 0; reg_write_m = 1; rd_m = 5'd3;
      result_src_m = RES_LOAD; funct3_m = F3_LW; read_valid_m = 0;
      @(posedge clk); #1;
      checkOutput("midwait_stall", load_stall_o, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; valid_m = 0;
      @(posedge clk); #1;
      checkOutput("midwait_stall_after_rst", load_stall_o, 1'b0);
      checkOutput("midwait_valid_w", valid_w, 1'b0);
      checkOutput("midwait_reg_write_w", reg_write_w, 1'b0);
      checkOutput("midwait_rd_w", rd_w, 5'd0);
      checkOutput("midwait_result_w", result_w, 32'd0);
      checkOutput("midwait_err_cleared", load_err_o, 1'b0);
`ifdef WB_RETIRE_COUNT_EN
      checkOutput("midwait_retire_count", retire_count_o, RW'(0));
`endif
      rst = 1'b0;
      err_model = 1'b0;
      retired_model = 0;
      applyStimulus(1, 0, 1, 5'd21, RES_ALU, 3'd0, 32'hCAFE, 0, 0, 0, 0);
      valid_m = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("final_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Parametrised MEM/WB pipeline register plus writeback result selection for the RISC-V core. Sits between the data-memory stage and the register file.
- Generalises the 2-way ALU/load result mux to a 4-source select with load byte/half extraction and sign/zero extension.
- Tolerates variable-latency data memory via a RUN/WAIT handshake with timeout.
- Drives the register-file write port and the W-stage forwarding bus.

Parameters:
- XLEN, 32, datapath width; must be ≥32.
- REG_AW, 5, register address width.
- LOAD_TIMEOUT, 16, maximum WAIT cycles before a load is abandoned; must be ≥1.
- RETIRE_W, 64, retire counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_m  in  1  M-stage holds a real instruction.
- flush_m  in  1  kill the M-stage instruction (turn it into a bubble).
- reg_write_m  in  1  instruction writes rd.
- rd_m  in  REG_AW  destination register.
- result_src_m  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
- funct3_m  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- alu_result_m  in  XLEN  ALU result; bits [1:0] are the load byte offset.
- pc_plus4_m  in  XLEN  PC+4 of the instruction.
- imm_ext_m  in  XLEN  extended immediate.
- read_data_m  in  XLEN  memory read word.
- read_valid_m  in  1  read_data_m is valid this cycle.
- valid_w  out  1  W stage holds a retiring instruction.
- reg_write_w  out  1  register-file write enable.
- rd_w  out  REG_AW  register-file write address.
- result_w  out  XLEN  register-file write data and forwarding value.
- load_stall_o  out  1  hold M and all earlier stages.
- load_err_o  out  1  sticky load-timeout flag.

Behaviour:
- Reset (rst=1 at clk edge): state RUN; all outputs 0; wait counter 0; load_err_o 0; any pending load discarded, including mid-WAIT.
- Latency: one cycle from an M-stage input to W-stage outputs, except for loads that enter WAIT.
- reg_write_w = valid_w & reg_write_q & (rd_w != 0). It is combinational from registered state, so an x0 write is never issued.
- A load is valid_m & !flush_m & result_src_m==01.
- RUN, on each edge:
  - flush_m=1 or valid_m=0: valid_w ← 0.
  - Load with read_valid_m=0: capture rd, reg_write, funct3 and offset into a pending buffer; valid_w ← 0; go to WAIT; wait counter ← 1.
  - Otherwise: capture all fields; valid_w ← 1; result_w ← the selected source; load data is extracted from read_data_m.
- WAIT:
  - load_stall_o = 1; it is a registered function of state, so it is high exactly while in WAIT.
  - M inputs, including flush_m, are ignored because upstream holds them.
  - valid_w = 0 each cycle.
  - read_valid_m=1: retire the pending load with the extracted data; valid_w ← 1; go to RUN.
  - read_valid_m=0 and wait counter == LOAD_TIMEOUT: retire with result_w=0 and reg_write suppressed; load_err_o ← 1 (sticky until rst); go to RUN.
  - read_valid_m=0 otherwise: wait counter increments.
- If read_valid_m arrives in the same cycle as the timeout compare, the data wins.
- Load extraction:
  - sh = read_data_m >> (8*offset).
  - LB/LBU: sign- or zero-extend sh[7:0]. LH/LHU: sign- or zero-extend sh[15:0]. LW: sign-extend sh[31:0] to XLEN.
  - Misaligned halfword/word: use the shifted value as-is, with the missing upper bytes zero before extension. No trap.
  - Any other funct3 is treated as LW.
- The offset is taken from alu_result_m[1:0] captured at acceptance.

Optional Feature:
- WB_RETIRE_COUNT_EN defined:
  - Adds output retire_count_o [RETIRE_W-1:0].
  - Increments by 1 on every cycle where valid_w=1, including timed-out loads.
  - Reset to 0; wraps modulo 2^RETIRE_W.
- Not defined: no port, no counter logic.

Decomposition:
- Shared package wb_pkg:
  - result-source encodings RES_ALU, RES_LOAD, RES_PC4, RES_IMM;
  - funct3 load encodings F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - state enum WB_RUN, WB_WAIT.
- One sub-module, load_extract: purely combinational offset shift plus extension, tested standalone.

Test Plan:
- ALU op: valid_m=1, src=00, rd=5, alu=0x8 → next cycle valid_w=1, reg_write_w=1, rd_w=5, result_w=0x00000008.
- Zero-wait loads: read_data=0x80FF7F01, read_valid=1:
  - LB at offset 2 → result_w=0xFFFFFFFF.
  - LBU at offset 3 → 0x00000080.
  - LH at offset 0 → 0x00007F01.
  - LHU at offset 2 → 0x000080FF.
- Delayed load: LW with read_valid low for 3 cycles → load_stall_o high for exactly 3 cycles; result_w=data on the cycle after read_valid; one retire.
- Timeout: LOAD_TIMEOUT=4, read_valid never high → WAIT for 4 cycles; then valid_w=1, reg_write_w=0, load_err_o=1 and held until rst.
- Flush and x0:
  - flush_m=1 on a valid ALU op → valid_w=0.
  - rd_m=0 with reg_write_m=1 → reg_write_w=0.
  - PC+4 source with pc_plus4=0x104 → result_w=0x104.
- Reset mid-WAIT: assert rst during WAIT → next cycle state RUN, load_stall_o=0, all outputs 0. With WB_RETIRE_COUNT_EN, retire_count_o returns to 0.
